// File: rtl/mux_sel_pkg.sv
// Shared definitions for the mux select sequencer.
//   NUM_CH / IDX_W : channel count and channel-index width
//   state_t        : sequencer states
//   idx_to_onehot  : channel index -> one-hot grant vector
package mux_sel_pkg;

   localparam int NUM_CH = 4;
   localparam int IDX_W  = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   function automatic logic [NUM_CH-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_CH-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/mux_sel_ctrl_rr_pick4.sv
// Combinational round-robin picker over four requests.
//   req   : per-channel request vector
//   ptr   : highest-priority channel; scan order ptr, ptr+1, ptr+2, ptr+3
//   found : at least one request is set
//   pick  : index of the first set request in scan order (ptr when none)
module rr_pick4
   import mux_sel_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic              found,
   output logic [IDX_W-1:0]  pick
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      found = 1'b0;
      pick  = ptr;
      cand  = ptr;
      for (int i = 0; i < NUM_CH; i++) begin
         // 2-bit wrap gives the modulo-4 scan for free
         cand = ptr + IDX_W'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

endmodule

// File: rtl/mux_sel_ctrl.sv
// Round-robin select sequencer for the 4:1 data mux.
//   clk, rst        : clock, asynchronous active-high reset
//   en              : arbitration enable; low releases the current grant
//   req[3:0]        : channel requests (bit i -> mux input in(i+1))
//   cntrl1, cntrl2  : mux select MSB / LSB, updated only when a grant starts
//   sel_valid       : mux output is a granted, stable source
//   grant[3:0]      : one-hot of granted channel, zero when not valid
//   sel_start       : pulse on the first cycle of each grant
//
// state | meaning
// IDLE  | no grant; arbitrate each cycle while en is high
// HOLD  | channel idx granted; counts up to HOLD_CYCLES cycles
// GAP   | single dead cycle after a grant; arbitrates like IDLE
module mux_sel_ctrl
   import mux_sel_pkg::*;
#(
   parameter int HOLD_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NUM_CH-1:0] req,
   output logic              cntrl1,
   output logic              cntrl2,
   output logic              sel_valid,
   output logic [NUM_CH-1:0] grant,
   output logic              sel_start
);

   localparam logic [7:0] CNT_LAST = 8'(HOLD_CYCLES - 1);

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] idx;
   logic [7:0]       cnt;
   logic             found;
   logic [IDX_W-1:0] pick;
   logic             hold_done;

   rr_pick4 u_pick (
      .req   (req),
      .ptr   (ptr),
      .found (found),
      .pick  (pick)
   );

   assign hold_done = !req[idx] || (cnt == CNT_LAST) || !en;

   // Outputs are loaded together with the state transition so they always
   // describe the state being entered; nothing combinational reaches a pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         idx       <= '0;
         cnt       <= '0;
         cntrl1    <= 1'b0;
         cntrl2    <= 1'b0;
         sel_valid <= 1'b0;
         grant     <= '0;
         sel_start <= 1'b0;
      end else begin
         sel_start <= 1'b0;
         case (state)
            HOLD: begin
               if (hold_done) begin
                  state     <= GAP;
                  ptr       <= idx + 2'd1;
                  sel_valid <= 1'b0;
                  grant     <= '0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
               // IDLE and GAP share the arbitration rule
               if (en && found) begin
                  state     <= HOLD;
                  idx       <= pick;
                  cnt       <= '0;
                  cntrl1    <= pick[1];
                  cntrl2    <= pick[0];
                  sel_valid <= 1'b1;
                  grant     <= idx_to_onehot(pick);
                  sel_start <= 1'b1;
               end else begin
                  state     <= IDLE;
                  sel_valid <= 1'b0;
                  grant     <= '0;
               end
            end
         endcase
      end
   end

endmodule
